// File: rtl/pc_fetch_ctrl_if.sv
// rtl/pc_fetch_ctrl_if.sv - fetch-side bus between the PC controller and the IF stage
//
// Purpose: groups the stall/redirect inputs, the incrementer return value and
//          the PC outputs of pc_fetch_ctrl into one bundle.
// Signals:
//   Stall            hazard stall from decode (hold PC)
//   Pc_Add1_In       Pc_Out + 1 from the external incrementer
//   Br_Taken         branch resolved taken this cycle
//   Br_Target        branch target word address
//   Jmp_En           j/jal/jr redirect this cycle
//   Jmp_Target       jump target word address
//   Pc_Out           current fetch PC
//   Pc_Valid         Pc_Out is a real fetch (low in BOOT)
//   Redirect_Pending a buffered redirect is waiting
// Modports: slave = the PC controller, master = the pipeline side driving it.
interface pc_fetch_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              Stall;
  logic [ADDR_W-1:0] Pc_Add1_In;
  logic              Br_Taken;
  logic [ADDR_W-1:0] Br_Target;
  logic              Jmp_En;
  logic [ADDR_W-1:0] Jmp_Target;
  logic [ADDR_W-1:0] Pc_Out;
  logic              Pc_Valid;
  logic              Redirect_Pending;

  modport slave (
    input  Stall, Pc_Add1_In, Br_Taken, Br_Target, Jmp_En, Jmp_Target,
    output Pc_Out, Pc_Valid, Redirect_Pending
  );

  modport master (
    output Stall, Pc_Add1_In, Br_Taken, Br_Target, Jmp_En, Jmp_Target,
    input  Pc_Out, Pc_Valid, Redirect_Pending
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - program counter register and next-PC selector for the IF stage
//
// Purpose: holds the fetch PC, selects the next PC from jump, branch, a
//          buffered redirect or the sequential (Pc + 1) value, holds on stall
//          and buffers redirects that arrive while stalled.
// Ports:
//   Clk      in  rising-edge clock
//   Reset_N  in  asynchronous active-low reset
//   bus      slave modport of pc_fetch_ctrl_if (stall/redirect in, PC out)
// Parameters:
//   ADDR_W   PC width, word addressed
//   RESET_PC PC loaded on reset
module pc_fetch_ctrl #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic            Clk,
  input  logic            Reset_N,
  pc_fetch_ctrl_if.slave  bus
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] r_pend_pc;
  logic [ADDR_W-1:0] w_pend_pc_nxt;
  logic              r_pend;
  logic              w_pend_nxt;
  logic              w_pc_valid;

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_state   <= BOOT;
      r_pc      <= RESET_PC;
      r_pend_pc <= '0;
      r_pend    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_pend_pc <= w_pend_pc_nxt;
      r_pend    <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_pend_pc_nxt = r_pend_pc;
    w_pend_nxt    = r_pend;
    w_pc_valid    = 1'b0;

    case (r_state)
      BOOT: begin
        // One settling cycle: the reset PC is not yet a real fetch and all
        // stall/redirect inputs are ignored.
        w_state_nxt = RUN;
      end

      RUN: begin
        w_pc_valid = 1'b1;
        if (!bus.Stall) begin
          // Any fresh redirect supersedes the buffered one, so the buffer is
          // consumed whenever any redirect source is taken.
          if (bus.Jmp_En) begin
            w_pc_nxt   = bus.Jmp_Target;
            w_pend_nxt = 1'b0;
          end else if (bus.Br_Taken) begin
            w_pc_nxt   = bus.Br_Target;
            w_pend_nxt = 1'b0;
          end else if (r_pend) begin
            w_pc_nxt   = r_pend_pc;
            w_pend_nxt = 1'b0;
          end else begin
            // Incrementer output wraps naturally; loaded as-is.
            w_pc_nxt = bus.Pc_Add1_In;
          end
        end else begin
          // Stalled: PC held, latest redirect overwrites the buffer.
          if (bus.Jmp_En) begin
            w_pend_pc_nxt = bus.Jmp_Target;
            w_pend_nxt    = 1'b1;
          end else if (bus.Br_Taken) begin
            w_pend_pc_nxt = bus.Br_Target;
            w_pend_nxt    = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = BOOT;
      end
    endcase
  end

  assign bus.Pc_Out           = r_pc;
  assign bus.Pc_Valid         = w_pc_valid;
  assign bus.Redirect_Pending = r_pend;

endmodule
